delta_spike_encoder: RTL and testbench

//  Per-channel delta-modulation spike generator, downstream of the gain multiplier stage (unsigned 15b

---
 rtl/delta_spike_encoder_pkg.sv | 18 +
 rtl/delta_spike_encoder_ref_mem.sv | 44 ++++
 rtl/delta_spike_encoder.sv | 168 ++++++++++++++++
 tb/tb_delta_spike_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_spike_encoder_pkg.sv
// Shared types and default constants for the delta-modulation spike encoder.
package delta_enc_pkg;

    localparam int DEF_DATA_W  = 15;
    localparam int DEF_NUM_CH  = 16;
    localparam int DEF_CH_W    = 4;
    localparam int DEF_MAX_SPK = 8;

    localparam logic POL_UP   = 1'b1;
    localparam logic POL_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        EMIT
    } state_t;

endpackage

// File: rtl/delta_spike_encoder_ref_mem.sv
// Per-channel reference levels and "initialised" flags.
// Asynchronous read port, one write port and a bulk flag clear.
module delta_ref_mem #(
    parameter int DATA_W = 15,
    parameter int NUM_CH = 16,
    parameter int CH_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear_all,
    input  logic [CH_W-1:0]   i_rd_chan,
    output logic [DATA_W-1:0] o_rd_ref,
    output logic              o_rd_init,
    input  logic              i_wr_en,
    input  logic [CH_W-1:0]   i_wr_chan,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] r_ref [NUM_CH];
    logic [NUM_CH-1:0] r_init;

    // NOTE: the reference array is reset because every channel must restart
    //       from level 0; that forces flops rather than a RAM macro here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ref[i] <= '0;
            end
            r_init <= '0;
        end else begin
            if (i_clear_all) begin
                r_init <= '0;
            end
            if (i_wr_en) begin
                r_ref[i_wr_chan]  <= i_wr_data;
                r_init[i_wr_chan] <= 1'b1;
            end
        end
    end

    assign o_rd_ref  = r_ref[i_rd_chan];
    assign o_rd_init = r_init[i_rd_chan];

endmodule

// File: rtl/delta_spike_encoder.sv
// Delta-modulation spike encoder: one UP/DOWN event per threshold step the
// new sample has moved from the channel reference, capped at MAX_SPK events.
module delta_spike_encoder
    import delta_enc_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CH_W    = DEF_CH_W,
    parameter int MAX_SPK = DEF_MAX_SPK
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] thresh,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_chan,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic [CH_W-1:0]   spk_chan,
    output logic              spk_pol,
    output logic              sat_pulse
);

    localparam int                CNT_W    = $clog2(MAX_SPK + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_SPK);
    localparam logic [CH_W:0]     NUM_CH_L = (CH_W + 1)'(NUM_CH);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_wref;
    logic [DATA_W-1:0] r_thr;
    logic [CH_W-1:0]   r_chan;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pol;
    logic              r_sat;

    logic [DATA_W-1:0] w_rd_ref;
    logic              w_rd_init;
    logic              w_wr_en;
    logic [CH_W-1:0]   w_wr_chan;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_clear_all;

    logic signed [DATA_W:0] w_delta;
    logic signed [DATA_W:0] w_thr_s;
    logic w_ge_up, w_ge_dn, w_room, w_accept, w_chan_ok, w_init_only;

    delta_ref_mem #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_ref_mem (
        .i_clk       (ap_clk),
        .i_rst       (ap_rst),
        .i_clear_all (w_clear_all),
        .i_rd_chan   (in_chan),
        .o_rd_ref    (w_rd_ref),
        .o_rd_init   (w_rd_init),
        .i_wr_en     (w_wr_en),
        .i_wr_chan   (w_wr_chan),
        .i_wr_data   (w_wr_data)
    );

    assign in_ready    = (r_state == IDLE) && !clear && !ap_rst;
    assign w_accept    = in_valid && in_ready;
    assign w_chan_ok   = ({1'b0, in_chan} < NUM_CH_L);
    assign w_init_only = !w_rd_init || (thresh == '0);
    assign w_clear_all = (r_state == IDLE) && clear;

    assign w_delta = $signed({1'b0, r_data}) - $signed({1'b0, r_wref});
    assign w_thr_s = $signed({1'b0, r_thr});
    assign w_ge_up = (w_delta >= w_thr_s);
    assign w_ge_dn = (w_delta <= -w_thr_s);
    assign w_room  = (r_cnt < MAX_CNT);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block is given a default first so that no
    //       path through the case leaves a signal unassigned (no latches).
    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        w_wr_chan = r_chan;
        w_wr_data = r_wref;
        unique case (r_state)
            IDLE: begin
                if (w_accept && w_chan_ok) begin
                    if (w_init_only) begin
                        w_wr_en   = 1'b1;
                        w_wr_chan = in_chan;
                        w_wr_data = in_data;
                    end else begin
                        w_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (w_room && (w_ge_up || w_ge_dn)) begin
                    w_next = EMIT;
                end else begin
                    // Residual below one step stays in the reference.
                    w_wr_en = 1'b1;
                    w_next  = IDLE;
                end
            end
            EMIT: begin
                if (spk_ready) begin
                    w_next = CHECK;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    //       register sees the pre-edge value of every other register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_data <= '0;
            r_wref <= '0;
            r_thr  <= '0;
            r_chan <= '0;
            r_cnt  <= '0;
            r_pol  <= POL_DOWN;
            r_sat  <= 1'b0;
        end else begin
            r_sat <= (r_state == CHECK) && !w_room && (w_ge_up || w_ge_dn);
            unique case (r_state)
                IDLE: begin
                    if (w_accept && w_chan_ok && !w_init_only) begin
                        r_data <= in_data;
                        r_chan <= in_chan;
                        r_thr  <= thresh;
                        r_cnt  <= '0;
                        r_wref <= w_rd_ref;
                    end
                end
                CHECK: begin
                    if (w_room && (w_ge_up || w_ge_dn)) begin
                        r_pol <= w_ge_up ? POL_UP : POL_DOWN;
                    end
                end
                EMIT: begin
                    if (spk_ready) begin
                        r_wref <= (r_pol == POL_UP) ? (r_wref + r_thr) : (r_wref - r_thr);
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spk_valid = (r_state == EMIT);
    assign spk_chan  = r_chan;
    assign spk_pol   = r_pol;
    assign sat_pulse = r_sat;

endmodule

// File: tb/tb_delta_spike_encoder.sv
// Scoreboard bench for delta_spike_encoder: an arithmetic reference model
// queues expected spikes per sample, a monitor pops them on each handshake.
module tb_delta_spike_encoder;

    localparam int DATA_W  = 15;
    localparam int NUM_CH  = 16;
    localparam int CH_W    = 4;
    localparam int MAX_SPK = 8;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic            pol;
    } spk_t;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic              clear;
    logic [DATA_W-1:0] thresh;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CH_W-1:0]   in_chan;
    logic              spk_valid;
    logic              spk_ready;
    logic [CH_W-1:0]   spk_chan;
    logic              spk_pol;
    logic              sat_pulse;

    spk_t q_exp[$];
    int   model_ref  [NUM_CH];
    bit   model_init [NUM_CH];
    int   exp_sat = 0;
    int   obs_sat = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    delta_spike_encoder #(
        .DATA_W  (DATA_W),
        .NUM_CH  (NUM_CH),
        .CH_W    (CH_W),
        .MAX_SPK (MAX_SPK)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .clear     (clear),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_chan   (in_chan),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_chan  (spk_chan),
        .spk_pol   (spk_pol),
        .sat_pulse (sat_pulse)
    );

    always #5 ap_clk = ~ap_clk;

    // Handshake completes on the next rising edge; spk_ready only changes just after rising edges.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (sat_pulse) obs_sat++;
            if (spk_valid && spk_ready) begin
                n_cmp++;
                if (q_exp.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_spike: got chan=%0d pol=%0d, expected no spike", spk_chan, spk_pol);
                end else begin
                    spk_t e;
                    e = q_exp.pop_front();
                    if ({spk_chan, spk_pol} !== {e.ch, e.pol}) begin
                        n_err++;
                        $display("FAIL spike: got chan=%0d pol=%0d, expected chan=%0d pol=%0d",
                                 spk_chan, spk_pol, e.ch, e.pol);
                    end
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            model_ref[i]  = 0;
            model_init[i] = 1'b0;
        end
        q_exp.delete();
    endtask

    task automatic model_push(input int ch, input int d, input int t);
        int   delta, mag, n;
        spk_t s;
        if (!model_init[ch] || t == 0) begin
            model_ref[ch]  = d;
            model_init[ch] = 1'b1;
        end else begin
            delta = d - model_ref[ch];
            mag   = (delta < 0) ? -delta : delta;
            n     = mag / t;
            if (n > MAX_SPK) begin
                n = MAX_SPK;
                exp_sat++;
            end
            s.ch  = CH_W'(ch);
            s.pol = (delta > 0);
            for (int k = 0; k < n; k++) q_exp.push_back(s);
            model_ref[ch] = (delta > 0) ? model_ref[ch] + n * t : model_ref[ch] - n * t;
        end
    endtask

    // Returns 1 ns after the accepting rising edge.
    task automatic send(input int ch, input int d, input int t);
        int guard = 0;
        model_push(ch, d, t);
        @(negedge ap_clk);
        in_valid = 1'b1;
        in_chan  = CH_W'(ch);
        in_data  = DATA_W'(d);
        thresh   = DATA_W'(t);
        while (!in_ready && guard < 200) begin
            @(negedge ap_clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0 for chan=%0d, expected 1", ch);
        end
        @(posedge ap_clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        @(negedge ap_clk);
        while (!(q_exp.size() == 0 && in_ready && !spk_valid) && guard < 500) begin
            @(negedge ap_clk);
            guard++;
        end
        @(negedge ap_clk);
        n_cmp++;
        if (guard >= 500) begin
            n_err++;
            $display("FAIL %s_done: %0d spikes still pending, expected 0", tag, q_exp.size());
        end
        n_cmp++;
        if (obs_sat !== exp_sat) begin
            n_err++;
            $display("FAIL %s_sat: got %0d sat pulses, expected %0d", tag, obs_sat, exp_sat);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, spk_valid, spk_chan, spk_pol, sat_pulse} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%0d v=%0d ch=%0d pol=%0d sat=%0d, expected all 0",
                     in_ready, spk_valid, spk_chan, spk_pol, sat_pulse);
        end
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got in_ready=%0d, expected 1", in_ready);
        end
    endtask

    task automatic test_up_basic();
        send(0, 1000, 100);
        send(0, 1350, 100);
        send(0, 1250, 100);
        send(0, 1400, 100);
        send(0, 5000, 0);
        send(0, 5100, 100);
        wait_done("up_basic");
    endtask

    task automatic test_down_latency();
        send(3, 2000, 100);
        wait_done("down_init");
        send(3, 1790, 100);
        n_cmp++;
        if (spk_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL latency_n1: got spk_valid=%0d in_ready=%0d, expected 0 0", spk_valid, in_ready);
        end
        @(posedge ap_clk);
        #1;
        n_cmp++;
        if (spk_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency_n2: got spk_valid=%0d, expected 1", spk_valid);
        end
        send(3, 1900, 100);
        wait_done("down");
    endtask

    task automatic test_saturation();
        send(5, 0, 10);
        send(5, 500, 10);
        send(5, 85, 10);
        send(5, 90, 10);
        wait_done("saturation");
    endtask

    task automatic test_backpressure();
        int   guard = 0;
        bit   stable_ok = 1'b1;
        logic [CH_W-1:0] h_ch;
        logic h_pol;
        send(6, 0, 100);
        send(6, 700, 100);
        while (q_exp.size() > 5 && guard < 100) begin
            @(posedge ap_clk);
            #1 guard++;
        end
        spk_ready = 1'b0;
        guard = 0;
        @(negedge ap_clk);
        while (!spk_valid && guard < 20) begin
            @(negedge ap_clk);
            guard++;
        end
        h_ch  = spk_chan;
        h_pol = spk_pol;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            if (!spk_valid || spk_chan !== h_ch || spk_pol !== h_pol || in_ready) stable_ok = 1'b0;
        end
        n_cmp++;
        if (!stable_ok || h_ch !== 4'd6 || h_pol !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_hold: got stable=%0d chan=%0d pol=%0d, expected 1 6 1",
                     stable_ok, h_ch, h_pol);
        end
        @(posedge ap_clk);
        #1 spk_ready = 1'b1;
        wait_done("backpressure");
    endtask

    task automatic test_clear();
        send(1, 100, 50);
        send(2, 200, 50);
        send(1, 250, 50);
        send(2, 100, 50);
        send(1, 300, 50);
        wait_done("interleave");
        @(negedge ap_clk);
        clear = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_ready: got in_ready=%0d, expected 0", in_ready);
        end
        @(negedge ap_clk);
        clear = 1'b0;
        for (int i = 0; i < NUM_CH; i++) model_init[i] = 1'b0;
        send(1, 1000, 50);
        send(2, 0, 50);
        send(1, 1100, 50);
        wait_done("clear");
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        send(7, 0, 100);
        send(7, 500, 100);
        while (q_exp.size() > 4 && guard < 100) begin
            @(posedge ap_clk);
            #1 guard++;
        end
        spk_ready = 1'b0;
        guard = 0;
        @(negedge ap_clk);
        while (!spk_valid && guard < 20) begin
            @(negedge ap_clk);
            guard++;
        end
        ap_rst = 1'b1;
        #1;
        n_cmp++;
        if (spk_valid !== 1'b0 || in_ready !== 1'b0 || sat_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got spk_valid=%0d in_ready=%0d sat=%0d, expected 0 0 0",
                     spk_valid, in_ready, sat_pulse);
        end
        model_reset();
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #1 spk_ready = 1'b1;
        send(7, 300, 100);
        send(7, 400, 100);
        send(0, 50, 100);
        send(0, 260, 100);
        wait_done("reset_mid");
    endtask

    initial begin
        clear     = 1'b0;
        thresh    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_chan   = '0;
        spk_ready = 1'b1;
        model_reset();
        test_reset();
        test_up_basic();
        test_down_latency();
        test_saturation();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
